// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the sum accumulator.
package sum_acc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } sum_acc_state_e;

  localparam int SUM_DATA_W = 8;
  localparam int SUM_ACC_W  = 16;
  localparam int SUM_COUNT  = 4;

endpackage

// File: rtl/sat_free_adder.sv
// Wrapping accumulate step: zero-extends the sample and keeps the carry-out
// so the caller can detect that the accumulator wrapped.
module sat_free_adder #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ACC_W:0]    sum_o
);

  // Both operands are unsigned; widening the sample never sign-extends.
  always_comb begin
    sum_o = {1'b0, acc_i} + (ACC_W+1)'(data_i);
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned samples into one frame result, offered on a
// valid/ready handshake with a sticky per-frame overflow flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACC   | accepting samples, in_ready=1
// HOLD  | frame result presented, waiting for out_ready; input stalled
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = SUM_DATA_W,
  parameter int ACC_W  = SUM_ACC_W,
  parameter int COUNT  = SUM_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_overflow,
  output logic [7:0]        sample_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

  sum_acc_state_e   state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W:0]   sum;
  logic             ovf_next;
  logic             accept;

  sat_free_adder #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i  (acc_q),
    .data_i (in_data),
    .sum_o  (sum)
  );

  // Handshake signals and carry accumulation for the current sample.
  always_comb begin
    in_ready = (state_q == ACC);
    accept   = in_valid && in_ready;
    ovf_next = ovf_q | sum[ACC_W];
  end

  // Next-state logic; clear aborts the frame but keeps the last out_data.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (clear) begin
      state_d     = ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      out_ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (accept) begin
            if (cnt_q == LAST_IDX) begin
              out_data_d  = sum[ACC_W-1:0];
              out_ovf_d   = ovf_next;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
              state_d     = HOLD;
            end else begin
              acc_d = sum[ACC_W-1:0];
              cnt_d = cnt_q + 8'd1;
              ovf_d = ovf_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_overflow = out_ovf_q;
  assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances (default, 9-bit accumulator,
// single-sample frames) share one stimulus stream and are each compared
// every cycle against a frame-total model, plus literal spot checks.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b0;

  logic        rdy_a, vld_a, ovf_a;
  logic [15:0] dat_a;
  logic [7:0]  cnt_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [8:0]  dat_b;
  logic [7:0]  cnt_b;
  logic        rdy_c, vld_c, ovf_c;
  logic [15:0] dat_c;
  logic [7:0]  cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT(4)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .out_valid(vld_a), .out_ready(out_ready), .out_data(dat_a),
    .out_overflow(ovf_a), .sample_cnt(cnt_a));

  sum_accumulator #(.DATA_W(8), .ACC_W(9), .COUNT(4)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .out_valid(vld_b), .out_ready(out_ready), .out_data(dat_b),
    .out_overflow(ovf_b), .sample_cnt(cnt_b));

  sum_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT(1)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_c),
    .in_data(in_data), .out_valid(vld_c), .out_ready(out_ready), .out_data(dat_c),
    .out_overflow(ovf_c), .sample_cnt(cnt_c));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: keep the true (unbounded) frame total; the result is that total
  // modulo 2^ACC_W, and overflow means the total did not fit.
  int  m_cnt_lim[3] = '{4, 4, 1};
  int  m_mod[3]     = '{65536, 512, 65536};
  int  m_total[3], m_cnt[3], m_out[3];
  bit  m_hold[3], m_valid[3], m_ovf[3];
  bit  started = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_total[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
        m_hold[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
      end else if (clear) begin
        m_total[k] = 0; m_cnt[k] = 0;
        m_hold[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
      end else if (!m_hold[k]) begin
        if (in_valid) begin
          m_total[k] += int'(in_data);
          if (m_cnt[k] == m_cnt_lim[k] - 1) begin
            m_out[k]   = m_total[k] % m_mod[k];
            m_ovf[k]   = (m_total[k] >= m_mod[k]);
            m_valid[k] = 1;
            m_hold[k]  = 1;
            m_total[k] = 0;
            m_cnt[k]   = 0;
          end else begin
            m_cnt[k]++;
          end
        end
      end else if (out_ready) begin
        m_valid[k] = 0;
        m_hold[k]  = 0;
      end
    end
    if (rst) started = 1'b1;
  end

  task automatic cmp(input int k, input string tag, input logic rdy, input logic vld,
                     input int dat, input logic ovf, input int cnt);
    check({tag, ".in_ready"}, int'(rdy), int'(!m_hold[k]));
    check({tag, ".out_valid"}, int'(vld), int'(m_valid[k]));
    check({tag, ".out_data"}, dat, m_out[k]);
    check({tag, ".out_overflow"}, int'(ovf), int'(m_ovf[k]));
    check({tag, ".sample_cnt"}, cnt, m_cnt[k]);
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp(0, "a", rdy_a, vld_a, int'(dat_a), ovf_a, int'(cnt_a));
      cmp(1, "b", rdy_b, vld_b, int'(dat_b), ovf_b, int'(cnt_b));
      cmp(2, "c", rdy_c, vld_c, int'(dat_c), ovf_c, int'(cnt_c));
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  int gap_v[7]   = '{1, 0, 0, 1, 0, 1, 1};
  int gap_d[7]   = '{5, 0, 0, 6, 0, 7, 8};
  int gap_cnt[7] = '{1, 1, 1, 2, 2, 3, 0};

  initial begin
    // Reset then a plain frame.
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    check("reset.out_valid", int'(vld_a), 0);
    check("reset.in_ready", int'(rdy_a), 1);
    check("reset.out_data", int'(dat_a), 0);
    check("reset.sample_cnt", int'(cnt_a), 0);
    step(1, 10, 1, 0);
    step(1, 20, 1, 0);
    step(1, 30, 1, 0);
    step(1, 40, 1, 0);
    check("frame1.out_valid", int'(vld_a), 1);
    check("frame1.out_data", int'(dat_a), 100);
    check("frame1.out_overflow", int'(ovf_a), 0);
    check("frame1.sample_cnt", int'(cnt_a), 0);
    step(0, 0, 1, 0);
    check("frame1.valid_drop", int'(vld_a), 0);
    check("frame1.ready_back", int'(rdy_a), 1);

    // Backpressure with a sample offered during HOLD.
    repeat (4) step(1, 255, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 255, 0, 0);
      check("bp.out_data", int'(dat_a), 1020);
      check("bp.in_ready", int'(rdy_a), 0);
      check("bp.sample_cnt", int'(cnt_a), 0);
    end
    step(0, 0, 1, 0);
    check("bp.release", int'(vld_a), 0);

    // Overflow on the 9-bit instance, then a clean frame.
    step(1, 200, 1, 0);
    step(1, 200, 1, 0);
    step(1, 200, 1, 0);
    step(1, 10, 1, 0);
    check("ovf.out_data", int'(dat_b), 98);
    check("ovf.out_overflow", int'(ovf_b), 1);
    check("ovf.wide_out_data", int'(dat_a), 610);
    check("ovf.wide_overflow", int'(ovf_a), 0);
    step(0, 0, 1, 0);
    repeat (4) step(1, 1, 1, 0);
    check("ovf2.out_data", int'(dat_b), 4);
    check("ovf2.out_overflow", int'(ovf_b), 0);
    step(0, 0, 1, 0);

    // Gapped input.
    for (int i = 0; i < 7; i++) begin
      step(gap_v[i][0], (gap_v[i] != 0) ? 8'(gap_d[i]) : 8'($urandom), 1, 0);
      check("gap.sample_cnt", int'(cnt_a), gap_cnt[i]);
    end
    check("gap.out_data", int'(dat_a), 26);
    check("gap.out_valid", int'(vld_a), 1);
    step(0, 0, 1, 0);

    // Clear mid-frame discards the concurrent sample.
    step(1, 50, 1, 0);
    step(1, 60, 1, 0);
    check("clr.pre_cnt", int'(cnt_a), 2);
    step(1, 99, 1, 1);
    check("clr.sample_cnt", int'(cnt_a), 0);
    check("clr.out_valid", int'(vld_a), 0);
    step(1, 1, 1, 0);
    step(1, 2, 1, 0);
    step(1, 3, 1, 0);
    step(1, 4, 1, 0);
    check("clr.out_data", int'(dat_a), 10);
    step(0, 0, 1, 0);

    // Reset while holding a result.
    step(1, 10, 0, 0);
    step(1, 20, 0, 0);
    step(1, 30, 0, 0);
    step(1, 40, 0, 0);
    check("rsthold.pre_data", int'(dat_a), 100);
    check("rsthold.pre_valid", int'(vld_a), 1);
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    check("rsthold.out_valid", int'(vld_a), 0);
    check("rsthold.out_data", int'(dat_a), 0);
    check("rsthold.in_ready", int'(rdy_a), 1);
    check("rsthold.sample_cnt", int'(cnt_a), 0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 79) == 0);
    end
    rst = 1'b0;
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the top-level 8-bit operand adder: consumes the stream of 8-bit sums and accumulates COUNT consecutive samples into one wider result.
- Presents the result on a valid/ready handshake to the output formatter.
- Flags arithmetic overflow per frame.
- Sits between the adder and the uo_out/uio_out pin muxing inside the tt_um top.

Parameters:
- DATA_W, 8: width of each incoming sum sample.
- ACC_W, 16: accumulator and result width; must be >= DATA_W.
- COUNT, 4: samples per frame; range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset. The top level drives it from the inverted rst_n.
- clear  input  1  synchronous frame abort; lower priority than rst.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  sum sample, unsigned.
- out_valid  output  1  result frame available.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  ACC_W  accumulated sum of COUNT samples, unsigned.
- out_overflow  output  1  frame sum exceeded 2^ACC_W-1; qualified by out_valid.
- sample_cnt  output  8  samples accepted so far in the current frame.

Behaviour:
- Synchronous active-high reset; one clock, clk.
- Two states: ACC and HOLD.
- Reset (rst=1 at a clock edge):
  - state=ACC, acc=0, sample_cnt=0.
  - out_valid=0, out_data=0, out_overflow=0, internal ovf=0.
  - in_ready=1 in the first cycle after reset.
- in_ready is combinational: 1 in ACC, 0 in HOLD.
- Accept event: in_valid && in_ready. Samples presented while in_ready=0 are ignored, with no side effect.
- ACC state, accept event:
  - Compute sum = acc + zero-extended in_data, at ACC_W+1 bits.
  - ovf_next = ovf | sum[ACC_W].
  - If sample_cnt < COUNT-1: acc <= sum[ACC_W-1:0]; sample_cnt++; ovf <= ovf_next.
  - If sample_cnt == COUNT-1 (last sample):
    - out_data <= sum[ACC_W-1:0]; out_overflow <= ovf_next; out_valid <= 1.
    - acc <= 0; sample_cnt <= 0; ovf <= 0; state <= HOLD.
- Latency: out_valid rises on the edge that accepts the last sample, so it is visible the following cycle.
- With COUNT=1, every accepted sample produces a frame.
- Overflow is sticky within a frame. acc wraps modulo 2^ACC_W and accumulation continues.
- HOLD state:
  - out_data and out_overflow stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid <= 0; state <= ACC.
  - A new sample can be accepted in the cycle after the handshake. There is no same-cycle pass-through, so the peak rate is COUNT samples per COUNT+1 cycles.
- ACC state ignores out_ready.
- clear=1 (and rst=0):
  - acc=0, sample_cnt=0, ovf=0, out_valid=0, out_overflow=0, state=ACC.
  - out_data keeps its last value.
  - Any sample offered in the same cycle is discarded. A pending HOLD result is dropped.
- rst=1 overrides clear and any in-flight handshake, including mid-frame and in HOLD.
- Arithmetic is unsigned only. in_data is zero-extended and never sign-extended.

Decomposition:
- Shared package sum_acc_pkg holds:
  - typedef enum {ACC, HOLD} for the state.
  - Default constants SUM_DATA_W=8, SUM_ACC_W=16, SUM_COUNT=4 for the top-level instantiation.
- Single module; no sub-module required.
- The accumulate-with-carry datapath may be factored into sat_free_adder. This is optional and purely combinational.

Test Plan:
- Reset then frame: rst for 2 cycles; feed 10,20,30,40 back-to-back with out_ready=1 → out_valid high for exactly 1 cycle after the 4th accept, out_data=100, out_overflow=0, sample_cnt returns to 0.
- Backpressure: COUNT=4, samples 255×4, out_ready=0 for 5 cycles → out_data=1020 held stable, in_ready=0 throughout HOLD; a 5th in_valid during HOLD is not counted; after out_ready=1, next frame starts clean.
- Overflow: ACC_W=9, COUNT=4, samples 200,200,200,10 → out_data=(610 mod 512)=98, out_overflow=1; the following frame 1,1,1,1 gives out_data=4, out_overflow=0.
- Gapped input: in_valid toggled 1,0,0,1,0,1,1 with data 5,x,x,6,x,7,8 → out_data=26; sample_cnt increments only on accept cycles.
- Clear mid-frame: accept 50,60, then clear=1 for one cycle with in_valid=1 and data 99 → sample discarded, sample_cnt=0; then 1,2,3,4 → out_data=10.
- Reset in HOLD: reach HOLD with out_data=100, assert rst with out_ready=0 → next cycle out_valid=0, out_data=0, in_ready=1, sample_cnt=0.
